phase_ctrl: RTL and testbench

Run/halt/single-step controller for the four-phase clock that drives the TMS9900 core. Sequences non-overlapping active-low phases phi1..phi4, one phase per clk12 cycle, and starts, stops and suspends them only at whole-cycle boundaries. Grants DMA/debug hold on request and counts completed machine cycles. Sits between the top-level clock/reset and the CPU core. It replaces free-running phase generation wherever the bench or debugger must control execution.

---
 rtl/phase_ctrl.sv | 134 +++++++++++++
 tb/tb_phase_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_ctrl.sv
// Run/halt/single-step controller for the TMS9900 four-phase clock: active-low phi1..phi4,
// one phase per clk12, starts/stops/holds only at cycle boundaries. Single-step requires PHASE_CTRL_STEP_EN.
module phase_ctrl #(
  parameter int CW = 16
) (
  input  logic          clk12,
  input  logic          reset,
  input  logic          run,
  input  logic          step,
  input  logic          hold_req,
  output logic          phi1,
  output logic          phi2,
  output logic          phi3,
  output logic          phi4,
  output logic          hold_ack,
  output logic          running,
  output logic [CW-1:0] cycles
);

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    STEP    = 2'd2,
    HOLD    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [CW-1:0]   cycles_q, cycles_d;
  logic [3:0]      phi_q, phi_d;
  logic            hold_ack_q, hold_ack_d;
  logic            running_q, running_d;
  logic            step_rise;

`ifdef PHASE_CTRL_STEP_EN
  logic step_q;

  always_ff @(posedge clk12 or posedge reset) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign step_rise = step & ~step_q;
`else
  logic unused_step;
  assign unused_step = step;
  assign step_rise   = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;

    unique case (state_q)
      STOPPED: begin
        if (hold_req) begin
          state_d = HOLD;
        end else if (run) begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end else if (step_rise) begin
          state_d = STEP;
          cnt_d   = 2'd0;
        end
      end
      RUN, STEP: begin
        // Inputs are only looked at once phi4 has completed.
        if (cnt_q != 2'd3) begin
          cnt_d = cnt_q + 2'd1;
        end else begin
          cycles_d = cycles_q + CW'(1);
          if (hold_req) begin
            state_d = HOLD;
          end else if (run) begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end else begin
            state_d = STOPPED;
            cnt_d   = 2'd3;
          end
        end
      end
      HOLD: begin
        if (!hold_req) begin
          if (run) begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end else begin
            state_d = STOPPED;
          end
        end
      end
      default: begin
        state_d = STOPPED;
        cnt_d   = 2'd3;
      end
    endcase

    // Outputs are decoded from the next state so they come straight out of flops.
    running_d  = (state_d == RUN) || (state_d == STEP);
    hold_ack_d = (state_d == HOLD);
    phi_d      = running_d ? ~(4'b0001 << cnt_d) : 4'hF;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk12 or posedge reset) begin
    if (reset) begin
      state_q    <= STOPPED;
      cnt_q      <= 2'd3;
      cycles_q   <= '0;
      phi_q      <= 4'hF;
      hold_ack_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cycles_q   <= cycles_d;
      phi_q      <= phi_d;
      hold_ack_q <= hold_ack_d;
      running_q  <= running_d;
    end
  end

  assign phi1     = phi_q[0];
  assign phi2     = phi_q[1];
  assign phi3     = phi_q[2];
  assign phi4     = phi_q[3];
  assign hold_ack = hold_ack_q;
  assign running  = running_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_phase_ctrl.sv
// Directed bench for phase_ctrl: a CW=16 and a CW=4 instance share stimulus; expectations
// are tracked by a phase number per tick and a completed-cycle count kept by the bench.
module tb_phase_ctrl;

`ifdef PHASE_CTRL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic        clk12;
  logic        reset;
  logic        run;
  logic        step;
  logic        hold_req;
  logic        phi1, phi2, phi3, phi4, hold_ack, running;
  logic [15:0] cycles;
  logic        b_phi1, b_phi2, b_phi3, b_phi4, b_hold_ack, b_running;
  logic [3:0]  cycles4;

  int          errors;
  int          checks;
  logic [15:0] exp_cyc;

  phase_ctrl #(.CW(16)) dut (
    .clk12(clk12), .reset(reset), .run(run), .step(step), .hold_req(hold_req),
    .phi1(phi1), .phi2(phi2), .phi3(phi3), .phi4(phi4),
    .hold_ack(hold_ack), .running(running), .cycles(cycles)
  );

  phase_ctrl #(.CW(4)) dut4 (
    .clk12(clk12), .reset(reset), .run(run), .step(step), .hold_req(hold_req),
    .phi1(b_phi1), .phi2(b_phi2), .phi3(b_phi3), .phi4(b_phi4),
    .hold_ack(b_hold_ack), .running(b_running), .cycles(cycles4)
  );

  initial begin
    clk12 = 1'b0;
    forever #5 clk12 = ~clk12;
  end

  // Expected {phi4..phi1} for phase p (1..4); 0 means all idle.
  function automatic logic [3:0] phase_vec(input int p);
    logic [3:0] v;
    v = 4'hF;
    if (p >= 1 && p <= 4) v[p-1] = 1'b0;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk12);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; run = 1'b0; step = 1'b0; hold_req = 1'b0;
    exp_cyc = '0;
    repeat (2) tick;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({phi4, phi3, phi2, phi1, running, hold_ack, cycles, cycles4} !== {4'hF, 1'b0, 1'b0, 16'd0, 4'd0}) begin
        errors++;
        $display("FAIL reset[%0d]: got phi=%b run=%b ack=%b cyc=%0d cyc4=%0d, want phi=1111 run=0 ack=0 cyc=0 cyc4=0",
                 i, {phi4, phi3, phi2, phi1}, running, hold_ack, cycles, cycles4);
      end
      reset = 1'b0;
      tick;
    end
  endtask

  task automatic test_free_run;
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (i % 4 == 0 && i > 0) exp_cyc++;
      checks++;
      if ({phi4, phi3, phi2, phi1, running, hold_ack} !== {phase_vec(i % 4 + 1), 1'b1, 1'b0} ||
          cycles !== exp_cyc || cycles4 !== exp_cyc[3:0]) begin
        errors++;
        $display("FAIL free_run[%0d]: got phi=%b run=%b ack=%b cyc=%0d cyc4=%0d, want phi=%b run=1 ack=0 cyc=%0d",
                 i, {phi4, phi3, phi2, phi1}, running, hold_ack, cycles, cycles4, phase_vec(i % 4 + 1), exp_cyc);
      end
    end
  endtask

  task automatic test_stop_mid_cycle;
    int seq_p [8] = '{1, 2, 3, 4, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      tick;
      if (i == 0 || i == 4) exp_cyc++;
      checks++;
      if ({phi4, phi3, phi2, phi1, running, hold_ack} !== {phase_vec(seq_p[i]), seq_p[i] != 0, 1'b0} ||
          cycles !== exp_cyc || cycles4 !== exp_cyc[3:0]) begin
        errors++;
        $display("FAIL stop[%0d]: got phi=%b run=%b ack=%b cyc=%0d, want phi=%b ack=0 cyc=%0d",
                 i, {phi4, phi3, phi2, phi1}, running, hold_ack, cycles, phase_vec(seq_p[i]), exp_cyc);
      end
      if (i == 1) run = 1'b0;
    end
  endtask

  task automatic test_step;
    for (int rep = 0; rep < 2; rep++) begin
      step = 1'b1;
      for (int i = 0; i < 7; i++) begin
        int p;
        if (i == 6) step = 1'b0;
        tick;
        p = (STEP_EN && i < 4) ? i + 1 : 0;
        if (STEP_EN && i == 4) exp_cyc++;
        checks++;
        if ({phi4, phi3, phi2, phi1, running, hold_ack} !== {phase_vec(p), p != 0, 1'b0} ||
            cycles !== exp_cyc || cycles4 !== exp_cyc[3:0]) begin
          errors++;
          $display("FAIL step%0d[%0d]: got phi=%b run=%b ack=%b cyc=%0d, want phi=%b cyc=%0d",
                   rep, i, {phi4, phi3, phi2, phi1}, running, hold_ack, cycles, phase_vec(p), exp_cyc);
        end
      end
    end
  endtask

  task automatic test_hold;
    // Per tick: expected phase, expected hold_ack, whether the cycle count advances.
    int seq_p  [14] = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4};
    bit seq_a  [14] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    bit seq_i  [14] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run = 1'b1;
    for (int i = 0; i < 15; i++) begin
      int p;
      bit a;
      tick;
      p = (i < 14) ? seq_p[i] : 0;
      a = (i < 14) ? seq_a[i] : 1'b0;
      if ((i < 14 && seq_i[i]) || i == 14) exp_cyc++;
      checks++;
      if ({phi4, phi3, phi2, phi1, running, hold_ack} !== {phase_vec(p), p != 0, a} ||
          cycles !== exp_cyc || cycles4 !== exp_cyc[3:0]) begin
        errors++;
        $display("FAIL hold[%0d]: got phi=%b run=%b ack=%b cyc=%0d, want phi=%b ack=%b cyc=%0d",
                 i, {phi4, phi3, phi2, phi1}, running, hold_ack, cycles, phase_vec(p), a, exp_cyc);
      end
      if (i == 0)  hold_req = 1'b1;
      if (i == 9)  hold_req = 1'b0;
      if (i == 10) run = 1'b0;
    end
  endtask

  task automatic test_simultaneous;
    // hold_req+run together from STOPPED, then run+step together from STOPPED.
    int seq_p [10] = '{0, 0, 0, 1, 2, 3, 4, 0, 0, 0};
    bit seq_a [10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    hold_req = 1'b1;
    run      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (i == 7) exp_cyc++;
      checks++;
      if ({phi4, phi3, phi2, phi1, running, hold_ack} !== {phase_vec(seq_p[i]), seq_p[i] != 0, seq_a[i]} ||
          cycles !== exp_cyc || cycles4 !== exp_cyc[3:0]) begin
        errors++;
        $display("FAIL simul[%0d]: got phi=%b run=%b ack=%b cyc=%0d, want phi=%b ack=%b cyc=%0d",
                 i, {phi4, phi3, phi2, phi1}, running, hold_ack, cycles, phase_vec(seq_p[i]), seq_a[i], exp_cyc);
      end
      if (i == 1) begin hold_req = 1'b0; run = 1'b0; end
      if (i == 2) begin run = 1'b1; step = 1'b1; end
      if (i == 3) run = 1'b0;
      if (i == 8) step = 1'b0;
    end
  endtask

  task automatic test_wrap;
    run = 1'b1;
    for (int c = 0; c < 18; c++) begin
      for (int p = 0; p < 4; p++) begin
        if (c == 17 && p == 3) break;
        tick;
        if (p == 0 && c > 0) exp_cyc++;
        checks++;
        if ({phi4, phi3, phi2, phi1, running} !== {phase_vec(p + 1), 1'b1} ||
            cycles !== exp_cyc || cycles4 !== exp_cyc[3:0]) begin
          errors++;
          $display("FAIL wrap[%0d.%0d]: got phi=%b cyc=%0d cyc4=%0d, want phi=%b cyc=%0d cyc4=%0d",
                   c, p, {phi4, phi3, phi2, phi1}, cycles, cycles4, phase_vec(p + 1), exp_cyc, exp_cyc[3:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_cycle;
    // Called with phi3 low; reset lands between edges and must act immediately.
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({phi4, phi3, phi2, phi1, running, hold_ack, cycles, cycles4} !== {4'hF, 1'b0, 1'b0, 16'd0, 4'd0}) begin
      errors++;
      $display("FAIL async_reset: got phi=%b run=%b ack=%b cyc=%0d cyc4=%0d, want phi=1111 run=0 ack=0 cyc=0 cyc4=0",
               {phi4, phi3, phi2, phi1}, running, hold_ack, cycles, cycles4);
    end
    exp_cyc = '0;
    tick;
    run   = 1'b0;
    reset = 1'b0;
    tick;
    checks++;
    if ({phi4, phi3, phi2, phi1, running, cycles, cycles4} !== {4'hF, 1'b0, 16'd0, 4'd0}) begin
      errors++;
      $display("FAIL post_reset: got phi=%b run=%b cyc=%0d cyc4=%0d, want phi=1111 run=0 cyc=0 cyc4=0",
               {phi4, phi3, phi2, phi1}, running, cycles, cycles4);
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    exp_cyc  = '0;
    reset    = 1'b1;
    run      = 1'b0;
    step     = 1'b0;
    hold_req = 1'b0;
    test_reset;
    test_free_run;
    test_stop_mid_cycle;
    test_step;
    test_hold;
    test_simultaneous;
    test_wrap;
    test_reset_mid_cycle;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
